// File: rtl/mc_run_scheduler.sv
// Monte-Carlo run scheduler: sequences LFSR seeding/advance and engine sample
// requests for N iterations, counts hits, and handles abort and engine timeout.
module mc_run_scheduler #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] num_of_iterations,
    input  logic             abort,
    output logic             load_seed,
    output logic             enable_rand,
    output logic             eng_req,
    input  logic             eng_ack,
    input  logic             eng_hit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             aborted,
    output logic             timeout_err
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        CHECK,
        GEN,
        REQ,
        FINISH
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_n;
    logic [WIDTH-1:0]  r_iter_cnt;
    logic [WIDTH-1:0]  r_hit_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WIDTH-1:0]  r_result;
    logic              r_result_valid;
    logic              r_aborted;
    logic              r_timeout_err;

    // Abort is only honoured while a run is actively stepping, not in IDLE/FINISH.
    logic w_abort_active;
    assign w_abort_active = abort && (r_state != IDLE) && (r_state != FINISH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_n            <= '0;
            r_iter_cnt     <= '0;
            r_hit_cnt      <= '0;
            r_wait_cnt     <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_aborted      <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else if (w_abort_active) begin
            // Abort outranks a same-cycle eng_ack, so that sample is dropped.
            r_aborted <= 1'b1;
            r_state   <= FINISH;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_n            <= num_of_iterations;
                        r_iter_cnt     <= '0;
                        r_hit_cnt      <= '0;
                        r_wait_cnt     <= '0;
                        r_result_valid <= 1'b0;
                        r_aborted      <= 1'b0;
                        r_timeout_err  <= 1'b0;
                        r_state        <= SEED;
                    end
                end
                SEED: begin
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (r_iter_cnt == r_n) begin
                        r_state <= FINISH;
                    end else begin
                        r_state <= GEN;
                    end
                end
                GEN: begin
                    r_state <= REQ;
                end
                REQ: begin
                    if (eng_ack) begin
                        r_iter_cnt <= r_iter_cnt + 1'b1;
                        r_hit_cnt  <= r_hit_cnt + WIDTH'(eng_hit);
                        r_wait_cnt <= '0;
                        r_state    <= CHECK;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_wait_cnt    <= '0;
                        r_state       <= FINISH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    r_result       <= r_hit_cnt;
                    r_result_valid <= 1'b1;
                    r_state        <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        start_ready = (r_state == IDLE);
        busy        = (r_state != IDLE);
        load_seed   = (r_state == SEED);
        enable_rand = (r_state == SEED) || (r_state == GEN);
        eng_req     = (r_state == REQ);
        done        = (r_state == FINISH);
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign aborted      = r_aborted;
    assign timeout_err  = r_timeout_err;

endmodule
